// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame-buffer writer: geometry defaults,
// bus register offsets and the writer state encoding.
package vga_pkg;

    localparam int H_PIX_DEF = 160;
    localparam int V_PIX_DEF = 120;

    localparam logic [2:0] OFF_X      = 3'd0;
    localparam logic [2:0] OFF_Y      = 3'd1;
    localparam logic [2:0] OFF_PIXEL  = 3'd2;
    localparam logic [2:0] OFF_CMD    = 3'd3;
    localparam logic [2:0] OFF_CFG_LO = 3'd4;
    localparam logic [2:0] OFF_CFG_HI = 3'd5;

    localparam logic [7:0] NUM_REGS = 8'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/vga_xy_counter.sv
// X/Y cursor with row-major wrap-around; shared by single-pixel
// auto-increment and the full-screen fill sweep.
module vga_xy_counter
    import vga_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       clear,
    input  logic       load_x,
    input  logic       load_y,
    input  logic [7:0] load_value,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    logic [7:0] x_r;
    logic [6:0] y_r;
    logic       row_end_s;
    logic       col_end_s;

    assign row_end_s = (x_r == 8'(H_PIX - 1));
    assign col_end_s = (y_r == 7'(V_PIX - 1));
    assign last      = row_end_s & col_end_s;
    assign x         = x_r;
    assign y         = y_r;

    // Cursor register: clear beats load, load beats step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_r <= 8'd0;
            y_r <= 7'd0;
        end else if (clear) begin
            x_r <= 8'd0;
            y_r <= 7'd0;
        end else if (load_x) begin
            x_r <= load_value;
        end else if (load_y) begin
            y_r <= load_value[6:0];
        end else if (step) begin
            if (row_end_s) begin
                x_r <= 8'd0;
                y_r <= col_end_s ? 7'd0 : y_r + 7'd1;
            end else begin
                x_r <= x_r + 8'd1;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

endmodule

// File: rtl/vga_fb_writer.sv
// Processor-bus front end that writes single pixels or fills the whole
// frame buffer, and holds the colour configuration word.
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         H_PIX     = H_PIX_DEF,
    parameter int         V_PIX     = V_PIX_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  BUS_ADDR,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        BUS_WE,
    output logic [14:0] FB_ADDR,
    output logic [7:0]  FB_DATA,
    output logic        FB_WE,
    output logic [15:0] CONFIG_COLOURS
);

    state_t      state_r;
    state_t      state_next_s;

    logic [7:0]  offset_s;
    logic        hit_s;
    logic [2:0]  sel_s;
    logic        wr_s;
    logic        rd_s;

    logic        step_s;
    logic        clear_s;
    logic        load_x_s;
    logic        load_y_s;
    logic        pix_wr_s;
    logic        fill_wr_s;

    logic [7:0]  x_s;
    logic [6:0]  y_s;
    logic        last_s;

    logic [14:0] fb_addr_r;
    logic [7:0]  fb_data_r;
    logic        fb_we_r;
    logic [15:0] cfg_r;
    logic [7:0]  rd_mux_s;
    logic [7:0]  read_data_r;
    logic        read_en_r;

    // Modulo subtraction keeps the window correct even near address 8'hFF.
    assign offset_s = BUS_ADDR - BASE_ADDR;
    assign hit_s    = (offset_s < NUM_REGS);
    assign sel_s    = offset_s[2:0];
    assign wr_s     = hit_s & BUS_WE;
    assign rd_s     = hit_s & ~BUS_WE;

    vga_xy_counter #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_xy (
        .clk        (CLK),
        .reset      (RESET),
        .step       (step_s),
        .clear      (clear_s),
        .load_x     (load_x_s),
        .load_y     (load_y_s),
        .load_value (BUS_DATA),
        .x          (x_s),
        .y          (y_s),
        .last       (last_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and cursor/write strobes; cursor-side writes only land in IDLE.
    always_comb begin
        state_next_s = state_r;
        step_s       = 1'b0;
        clear_s      = 1'b0;
        load_x_s     = 1'b0;
        load_y_s     = 1'b0;
        pix_wr_s     = 1'b0;
        fill_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_s) begin
                    case (sel_s)
                        OFF_X:     load_x_s = (BUS_DATA < 8'(H_PIX));
                        OFF_Y:     load_y_s = (BUS_DATA < 8'(V_PIX));
                        OFF_PIXEL: begin
                            pix_wr_s = 1'b1;
                            step_s   = 1'b1;
                        end
                        OFF_CMD: begin
                            if (BUS_DATA[0]) begin
                                state_next_s = ST_FILL;
                                clear_s      = 1'b1;
                            end else begin
                                state_next_s = ST_IDLE;
                            end
                        end
                        default: begin
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                fill_wr_s = 1'b1;
                step_s    = 1'b1;
                if (last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Read-back value for the addressed register.
    always_comb begin
        rd_mux_s = 8'h00;
        case (sel_s)
            OFF_X:      rd_mux_s = x_s;
            OFF_Y:      rd_mux_s = {1'b0, y_s};
            OFF_PIXEL:  rd_mux_s = 8'h00;
            OFF_CMD:    rd_mux_s = {7'd0, (state_r == ST_FILL)};
            OFF_CFG_LO: rd_mux_s = cfg_r[7:0];
            OFF_CFG_HI: rd_mux_s = cfg_r[15:8];
            default:    rd_mux_s = 8'h00;
        endcase
    end

    // Frame-buffer port, colour config and registered read data.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fb_we_r     <= 1'b0;
            fb_addr_r   <= 15'd0;
            fb_data_r   <= 8'h00;
            cfg_r       <= 16'h0000;
            read_en_r   <= 1'b0;
            read_data_r <= 8'h00;
        end else begin
            fb_we_r <= pix_wr_s | fill_wr_s;
            if (pix_wr_s | fill_wr_s) begin
                fb_addr_r <= {y_s, x_s};
            end else begin
                fb_addr_r <= fb_addr_r;
            end
            // The fill reuses the last pixel colour, so only PIXEL writes update it.
            if (pix_wr_s) begin
                fb_data_r <= BUS_DATA;
            end else begin
                fb_data_r <= fb_data_r;
            end
            if (wr_s && (sel_s == OFF_CFG_LO)) begin
                cfg_r[7:0] <= BUS_DATA;
            end else begin
                cfg_r[7:0] <= cfg_r[7:0];
            end
            if (wr_s && (sel_s == OFF_CFG_HI)) begin
                cfg_r[15:8] <= BUS_DATA;
            end else begin
                cfg_r[15:8] <= cfg_r[15:8];
            end
            read_en_r   <= rd_s;
            read_data_r <= rd_mux_s;
        end
    end

    assign FB_WE          = fb_we_r;
    assign FB_ADDR        = fb_addr_r;
    assign FB_DATA        = fb_data_r;
    assign CONFIG_COLOURS = cfg_r;
    assign BUS_DATA       = read_en_r ? read_data_r : {8{1'bz}};

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed self-checking bench for vga_fb_writer with a frame-buffer
// write monitor (pulse count, address coverage, range check).
module tb_vga_fb_writer;

    localparam logic [7:0] BASE = 8'hB0;
    localparam int         NPIX = 160 * 120;

    logic        clk;
    logic        reset;
    logic [7:0]  bus_addr;
    wire  [7:0]  bus_data;
    logic        bus_we;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic [15:0] config_colours;

    logic [7:0]  drv_data;
    logic        drv_en;
    assign bus_data = drv_en ? drv_data : {8{1'bz}};

    int tests;
    int fails;

    // Monitor state: cumulative counters, written only by the monitor.
    int   pulse_total;
    int   fill_total;
    int   dup_total;
    int   range_bad;
    int   seen_epoch [32768];
    int   epoch;
    logic fill_mon;

    vga_fb_writer #(
        .BASE_ADDR (BASE),
        .H_PIX     (160),
        .V_PIX     (120)
    ) dut (
        .CLK            (clk),
        .RESET          (reset),
        .BUS_ADDR       (bus_addr),
        .BUS_DATA       (bus_data),
        .BUS_WE         (bus_we),
        .FB_ADDR        (fb_addr),
        .FB_DATA        (fb_data),
        .FB_WE          (fb_we),
        .CONFIG_COLOURS (config_colours)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples the pre-edge view of the write port on every rising edge.
    always @(posedge clk) begin
        if (fb_we) begin
            pulse_total <= pulse_total + 1;
            if (fb_addr[7:0] >= 8'd160 || fb_addr[14:8] >= 7'd120) begin
                range_bad <= range_bad + 1;
            end
            if (fill_mon) begin
                fill_total <= fill_total + 1;
                if (seen_epoch[fb_addr] == epoch) begin
                    dup_total <= dup_total + 1;
                end
                seen_epoch[fb_addr] <= epoch;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [7:0] data);
        @(negedge clk);
        bus_addr = BASE + off;
        drv_data = data;
        drv_en   = 1'b1;
        bus_we   = 1'b1;
        @(negedge clk);
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [7:0] data);
        @(negedge clk);
        bus_addr = BASE + off;
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        @(negedge clk);
        data     = bus_data;
        bus_addr = 8'h00;
    endtask

    logic [7:0] rd;
    int         base_pulses;
    int         base_fill;
    int         base_dup;

    initial begin
        tests       = 0;
        fails       = 0;
        pulse_total = 0;
        fill_total  = 0;
        dup_total   = 0;
        range_bad   = 0;
        epoch       = 1;
        fill_mon    = 1'b0;
        for (int i = 0; i < 32768; i++) seen_epoch[i] = 0;
        reset    = 1'b0;
        bus_addr = 8'h00;
        bus_we   = 1'b0;
        drv_data = 8'h00;
        drv_en   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_cfg", 32'(config_colours), 32'd0);
        reset = 1'b1;
        bus_read(8'd0, rd); check("rst_x", 32'(rd), 32'd0);
        bus_read(8'd1, rd); check("rst_y", 32'(rd), 32'd0);
        bus_read(8'd3, rd); check("rst_status", 32'(rd), 32'd0);

        // Single pixel with auto-increment.
        bus_write(8'd0, 8'd5);
        bus_write(8'd1, 8'd3);
        bus_write(8'd2, 8'hE0);
        check("pix_we", 32'(fb_we), 32'd1);
        check("pix_addr", 32'(fb_addr), 32'h0305);
        check("pix_data", 32'(fb_data), 32'hE0);
        @(negedge clk);
        check("pix_we_pulse", 32'(fb_we), 32'd0);
        bus_read(8'd0, rd); check("pix_x_inc", 32'(rd), 32'd6);
        bus_read(8'd2, rd); check("pixel_read", 32'(rd), 32'd0);

        // Last pixel of the frame wraps both coordinates.
        bus_write(8'd0, 8'd159);
        bus_write(8'd1, 8'd119);
        bus_write(8'd2, 8'h1C);
        check("corner_we", 32'(fb_we), 32'd1);
        check("corner_addr", 32'(fb_addr), 32'h779F);
        check("corner_data", 32'(fb_data), 32'h1C);
        bus_read(8'd0, rd); check("corner_x_wrap", 32'(rd), 32'd0);
        bus_read(8'd1, rd); check("corner_y_wrap", 32'(rd), 32'd0);

        // Out-of-range coordinate writes are dropped.
        bus_write(8'd0, 8'd10);
        bus_write(8'd1, 8'd7);
        bus_write(8'd0, 8'd200);
        bus_write(8'd0, 8'd160);
        bus_write(8'd1, 8'd120);
        bus_read(8'd0, rd); check("x_oob_ignored", 32'(rd), 32'd10);
        bus_read(8'd1, rd); check("y_oob_ignored", 32'(rd), 32'd7);
        bus_write(8'd4, 8'h5A);
        bus_read(8'd4, rd); check("cfg_lo_rd", 32'(rd), 32'h5A);
        check("cfg_out", 32'(config_colours), 32'h005A);
        bus_write(8'd6, 8'h33);
        check("oob_addr_cfg", 32'(config_colours), 32'h005A);

        // Full-screen fill.
        base_pulses = pulse_total;
        bus_write(8'd2, 8'h03);
        check("fill_pix_addr", 32'(fb_addr), 32'h070A);
        @(negedge clk);
        base_fill = fill_total;
        base_dup  = dup_total;
        fill_mon  = 1'b1;
        bus_write(8'd3, 8'h01);
        bus_read(8'd3, rd); check("fill_status_busy", 32'(rd), 32'd1);
        bus_write(8'd2, 8'hFF);
        check("fill_pixel_ignored", 32'(fb_data), 32'h03);
        bus_write(8'd5, 8'hA5);
        check("fill_cfg_hi", 32'(config_colours), 32'hA55A);
        for (int i = 0; i < 25000 && (fill_total - base_fill) < NPIX; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("fill_count", 32'(fill_total - base_fill), 32'(NPIX));
        check("fill_dups", 32'(dup_total - base_dup), 32'd0);
        check("fill_total_pulses", 32'(pulse_total - base_pulses), 32'(NPIX + 1));
        check("fill_done_we", 32'(fb_we), 32'd0);
        bus_read(8'd3, rd); check("fill_status_idle", 32'(rd), 32'd0);
        bus_read(8'd0, rd); check("fill_end_x", 32'(rd), 32'd0);
        bus_read(8'd1, rd); check("fill_end_y", 32'(rd), 32'd0);
        bus_read(8'd5, rd); check("cfg_hi_rd", 32'(rd), 32'hA5);

        // Reset part way through a fill.
        epoch     = 2;
        base_fill = fill_total;
        bus_write(8'd3, 8'h01);
        for (int i = 0; i < 2000 && (fill_total - base_fill) < 1000; i++) @(negedge clk);
        check("abort_reached", 32'((fill_total - base_fill) >= 1000), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(fb_we), 32'd0);
        check("abort_addr", 32'(fb_addr), 32'd0);
        check("abort_data", 32'(fb_data), 32'd0);
        check("abort_cfg", 32'(config_colours), 32'd0);
        reset = 1'b1;
        base_pulses = pulse_total;
        repeat (40) @(negedge clk);
        check("abort_no_writes", 32'(pulse_total - base_pulses), 32'd0);
        bus_read(8'd3, rd); check("abort_status", 32'(rd), 32'd0);
        bus_read(8'd0, rd); check("abort_x", 32'(rd), 32'd0);
        check("range_violations", 32'(range_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_fb_writer.md
VGA_FB_WRITER -- requirements
Module: vga_fb_writer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'hB0, giving the base of its six bus registers (offsets 0-5).
REQ-002 The block SHALL have parameter H_PIX, default 160, giving the number of frame-buffer columns.
REQ-003 The block SHALL have parameter V_PIX, default 120, giving the number of frame-buffer rows.
REQ-004 The block SHALL have port CLK, input, 1 bit: 100 MHz system clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: reset; one clock, reset synchronous and active-low.
REQ-006 The block SHALL have port BUS_ADDR, input, 8 bits: processor bus address.
REQ-007 The block SHALL have port BUS_DATA, inout, 8 bits: processor data bus, tri-stated unless this block is driving a read.
REQ-008 The block SHALL have port BUS_WE, input, 1 bit: bus write strobe, one cycle per write.
REQ-009 The block SHALL have port FB_ADDR, output, 15 bits: frame-buffer write address {Y[6:0], X[7:0]}, the same packing the VGA read side uses.
REQ-010 The block SHALL have port FB_DATA, output, 8 bits: pixel colour to write.
REQ-011 The block SHALL have port FB_WE, output, 1 bit: frame-buffer write enable.
REQ-012 The block SHALL have port CONFIG_COLOURS, output, 16 bits: colour configuration word for the signal generator.

Function
REQ-013 The register map SHALL be: +0 X (RW, 8 bits); +1 Y (RW, 7 bits); +2 PIXEL (WO); +3 CMD/STATUS; +4 CONFIG_COLOURS[7:0] (RW); +5 CONFIG_COLOURS[15:8] (RW).
REQ-014 A write to X with a value >= H_PIX SHALL be ignored.
REQ-015 A write to Y with a value >= V_PIX SHALL be ignored.
REQ-016 A write of value c to PIXEL in IDLE SHALL, on the next cycle, assert FB_WE for exactly 1 cycle with FB_ADDR={Y,X} and FB_DATA=c.
REQ-017 After a PIXEL write, X SHALL auto-increment.
REQ-018 When X reaches H_PIX, X SHALL wrap to 0 and Y SHALL increment.
REQ-019 When Y reaches V_PIX, Y SHALL wrap to 0.
REQ-020 A write to CMD with bit0=1 in IDLE SHALL enter FILL, using the current FB_DATA colour register as the fill colour.
REQ-021 In FILL the block SHALL assert FB_WE every cycle while sweeping FB_ADDR row-major from {0,0} to {V_PIX-1,H_PIX-1}, giving H_PIX*V_PIX writes (19200 by default).
REQ-022 After the last fill write, the block SHALL return to IDLE on the following cycle.
REQ-023 At the end of FILL, X and Y SHALL both equal 0.
REQ-024 The state machine SHALL have exactly two states, IDLE and FILL, with transitions IDLE->FILL on a CMD fill write and FILL->IDLE after the last write or on reset.
REQ-025 While in FILL, writes to X, Y, PIXEL and CMD SHALL be ignored.
REQ-026 While in FILL, writes to CONFIG_COLOURS SHALL still be accepted.
REQ-027 A read of CMD/STATUS SHALL return {7'b0, BUSY}, where BUSY=1 in FILL.
REQ-028 Reads SHALL be registered: BUS_DATA is driven during the cycle following a read address match (BUS_WE=0), and is high-Z otherwise.
REQ-029 A read of PIXEL SHALL return 8'h00.
REQ-030 A bus address outside BASE_ADDR..BASE_ADDR+5 SHALL have no effect and SHALL leave BUS_DATA high-Z.
REQ-031 FB_WE SHALL never be asserted with FB_ADDR X>=H_PIX or Y>=V_PIX.

Reset
REQ-032 While RESET=0 at a clock edge, the following SHALL hold on the next cycle: state=IDLE, X=0, Y=0, FB_WE=0, FB_ADDR=0, FB_DATA=0, CONFIG_COLOURS=16'h0000, BUS_DATA high-Z.
REQ-033 A reset during FILL SHALL abort the fill, with FB_WE low on the next cycle and no further writes.

Structure
REQ-034 A shared package vga_pkg SHALL hold H_PIX/V_PIX defaults, the register offset constants and the IDLE/FILL state encoding.
REQ-035 The X/Y wrap-around pair SHALL be one sub-module, vga_xy_counter (inputs: step, clear, load-X, load-Y; outputs: X, Y, last), used for both auto-increment and fill.

Verification
REQ-036 The bench SHALL cover: write X=5, Y=3, PIXEL=8'hE0 -> 1 cycle later FB_WE=1, FB_ADDR=15'h0305, FB_DATA=E0; X then reads back 6.
REQ-037 The bench SHALL cover: X=159, Y=119, PIXEL=8'h1C -> write at {119,159}, then X reads 0 and Y reads 0.
REQ-038 The bench SHALL cover: write X=200 -> X is unchanged; write Y=120 -> Y is unchanged.
REQ-039 The bench SHALL cover: PIXEL=8'h03 then CMD=1 -> STATUS reads 1; exactly 19201 FB_WE pulses in total (the PIXEL write plus 19200 fill writes), the fill writes covering every address once, then STATUS reads 0.
REQ-040 The bench SHALL cover: during FILL, write PIXEL=8'hFF -> ignored (no FB_DATA change), while a CONFIG_COLOURS[15:8]=8'hA5 write is applied immediately.
REQ-041 The bench SHALL cover: RESET=0 at fill cycle 1000 -> FB_WE=0 on the next cycle, all outputs at reset values, and STATUS reads 0 after release.
